fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Parametrised instruction-fetch front end: owns the fetch PC and issues pipelined imem
//   requests with up to MAX_OUTSTANDING in flight. Buffers responses with their PCs in a
//   FIFO_DEPTH-entry queue and presents them to decode on a valid/ready handshake.
//   Supports redirect (branch/trap) with flush and discard of stale in-flight responses.
// PARAMETERS
//   XLEN            32  address/instruction width
//   RESET_PC        0   fetch PC after reset
//   FIFO_DEPTH      4   instruction queue entries (>=2)
//   MAX_OUTSTANDING 2   max accepted-but-unanswered imem requests (>=1, <=FIFO_DEPTH)
// PORTS
//   clk              in   1     clock, rising edge
//   reset_n          in   1     asynchronous, active-low reset
//   redirect_valid   in   1     load new fetch PC, flush queue
//   redirect_pc      in   XLEN  target PC; bits [1:0] ignored (treated as 0)
//   imem_req_valid   out  1     request valid
//   imem_req_ready   in   1     memory accepts request
//   imem_req_addr    out  XLEN  request address (= fetch_pc)
//   imem_resp_valid  in   1     response valid (in request order)
//   imem_resp_ready  out  1     constant 1 (space pre-reserved by credit rule)
//   imem_resp_data   in   XLEN  instruction word
//   imem_resp_err    in   1     access fault for this response
//   if_valid         out  1     queue head valid
//   if_ready         in   1     decode accepts head
//   if_pc            out  XLEN  PC of head
//   if_instr         out  XLEN  instruction of head
//   if_err           out  1     fault flag of head
// BEHAVIOUR
//   Reset (async assert, sync release): fetch_pc=RESET_PC; queue empty; outstanding=0;
//     drop_cnt=0; if_valid=0; imem_req_valid=0; if_pc/if_instr/if_err=0.
//   Issue: imem_req_valid = !redirect_valid && outstanding<MAX_OUTSTANDING &&
//     (count+outstanding)<FIFO_DEPTH. req_valid may deassert without a handshake.
//     On req handshake: fetch_pc+=4 (wraps mod 2^XLEN); fetch_pc is pushed into the
//     in-flight PC tag FIFO (depth MAX_OUTSTANDING); outstanding+=1.
//   Response: each imem_resp_valid pops one tag; outstanding-=1. If drop_cnt>0: discard,
//     drop_cnt-=1. Else push {tag,data,err} into queue. Credit rule guarantees no overflow;
//     push and pop in the same cycle are legal at any occupancy.
//   Output: head registered; response at cycle M -> if_valid at M+1 (no bypass). Pop on
//     if_valid&&if_ready. Outputs hold stable while if_valid&&!if_ready.
//   Redirect at cycle N (highest priority): fetch_pc<=redirect_pc&~3; queue cleared (any
//     same-cycle pop/push ignored); drop_cnt<=outstanding - (resp_valid&&drop_cnt==0 ? 1:0)
//     + ... i.e. every response still owed after N is dropped; response arriving in cycle N
//     is also dropped. No request handshake in cycle N. First request to redirect_pc at N+1.
//   Back-to-back redirects: last one wins; drop_cnt accumulates correctly.
//   Errors: imem_resp_err delivered as if_err on that entry; fetch continues sequentially.
//   Counters sized $clog2(MAX_OUTSTANDING+1); outstanding never exceeds MAX_OUTSTANDING.
// TESTING
//   1. Reset, imem ready, 1-cycle latency, if_ready=1 -> addrs 0,4,8,..., if_pc matches
//      addr, first if_valid 2 cycles after first req handshake, 1 instr/cycle steady.
//   2. if_ready=0 for 10 cycles -> exactly 4 entries queued, req_valid low, no overflow;
//      release -> entries PC 0,4,8,C in order.
//   3. Two requests in flight (0x10,0x14), redirect to 0x103 -> both responses discarded,
//      next req_addr 0x100, first if_pc 0x100.
//   4. Redirect coincident with resp_valid and if_ready -> response dropped, queue empty
//      next cycle, if_valid=0.
//   5. resp_err on PC 0x8 -> if_err=1 with if_pc 0x8 only; 0xC fetched normally.
//   6. reset_n low mid-stream -> outputs zero immediately (async); restart from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit and its environment: redirect, imem
// request/response channels and the decode-side valid/ready handshake.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic            imem_resp_ready;
  logic [XLEN-1:0] imem_resp_data;
  logic            imem_resp_err;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_err;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, imem_resp_err, if_ready,
    output imem_req_valid, imem_req_addr, imem_resp_ready, if_valid, if_pc,
           if_instr, if_err
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, imem_resp_err, if_ready,
    input  imem_req_valid, imem_req_addr, imem_resp_ready, if_valid, if_pc,
           if_instr, if_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps a bounded number of imem
// requests in flight, queues tagged responses and hands them to decode.
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}},
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          reset_n,
  fetch_unit_if.master bus_io
);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int QCW = $clog2(FIFO_DEPTH + 1);
  localparam int QPW = $clog2(FIFO_DEPTH);
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW  = QCW + 1;
  localparam logic [CW-1:0] MAX_OS  = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

  function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
    return (p == QPW'(FIFO_DEPTH - 1)) ? {QPW{1'b0}} : p + QPW'(1'b1);
  endfunction

  function automatic logic [TPW-1:0] t_inc(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUTSTANDING - 1)) ? {TPW{1'b0}} : p + TPW'(1'b1);
  endfunction

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            run_q;
  logic [CW-1:0]   os_q, os_d, drop_q, drop_d;
  logic [XLEN-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [TPW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [XLEN-1:0] q_pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0] q_instr_q [FIFO_DEPTH];
  logic            q_err_q   [FIFO_DEPTH];
  logic [QPW-1:0]  q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [QCW-1:0]  q_cnt_q, q_cnt_d;
  logic            head_valid_q, head_valid_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
  logic            head_err_q, head_err_d;

  logic [SW-1:0]   occ_s;
  logic [QCW-1:0]  cnt_pop_s;
  logic [XLEN-1:0] tag_s;
  logic            req_valid_s, req_fire_s, resp_s, drop_s, push_s, pop_s;

  // Handshake qualification; credits count queued entries plus requests still owed.
  always_comb begin
    occ_s       = SW'(q_cnt_q) + SW'(os_q);
    req_valid_s = run_q && !bus_io.redirect_valid && (os_q < MAX_OS) && (occ_s < DEPTH_S);
    req_fire_s  = req_valid_s && bus_io.imem_req_ready;
    resp_s      = bus_io.imem_resp_valid;
    drop_s      = (drop_q != {CW{1'b0}});
    push_s      = resp_s && !drop_s && !bus_io.redirect_valid;
    pop_s       = head_valid_q && bus_io.if_ready && !bus_io.redirect_valid;
    tag_s       = tag_mem_q[tag_rd_q];
  end

  // Next-state for PC, in-flight bookkeeping and queue pointers.
  always_comb begin
    fetch_pc_d = bus_io.redirect_valid ? (bus_io.redirect_pc & ~XLEN'(2'b11))
               : req_fire_s            ? fetch_pc_q + XLEN'(3'd4)
               :                         fetch_pc_q;
    os_d       = os_q + CW'(req_fire_s) - CW'(resp_s);
    // Everything owed after a redirect, plus a response arriving with it, is stale.
    drop_d     = bus_io.redirect_valid ? os_q - CW'(resp_s)
               : (resp_s && drop_s)    ? drop_q - CW'(1'b1)
               :                         drop_q;
    tag_wr_d   = req_fire_s ? t_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d   = resp_s ? t_inc(tag_rd_q) : tag_rd_q;
    cnt_pop_s  = q_cnt_q - QCW'(pop_s);
    q_cnt_d    = bus_io.redirect_valid ? {QCW{1'b0}} : cnt_pop_s + QCW'(push_s);
    q_rd_d     = bus_io.redirect_valid ? {QPW{1'b0}} : (pop_s ? q_inc(q_rd_q) : q_rd_q);
    q_wr_d     = bus_io.redirect_valid ? {QPW{1'b0}} : (push_s ? q_inc(q_wr_q) : q_wr_q);
  end

  // Registered head: the next head comes from storage, or from the pushed response when the queue drains.
  always_comb begin
    head_valid_d = 1'b0;
    head_pc_d    = {XLEN{1'b0}};
    head_instr_d = {XLEN{1'b0}};
    head_err_d   = 1'b0;
    if (q_cnt_d == {QCW{1'b0}}) begin
      head_valid_d = 1'b0;
    end else if (cnt_pop_s != {QCW{1'b0}}) begin
      head_valid_d = 1'b1;
      head_pc_d    = q_pc_q[q_rd_d];
      head_instr_d = q_instr_q[q_rd_d];
      head_err_d   = q_err_q[q_rd_d];
    end else begin
      head_valid_d = 1'b1;
      head_pc_d    = tag_s;
      head_instr_d = bus_io.imem_resp_data;
      head_err_d   = bus_io.imem_resp_err;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      run_q        <= 1'b0;
      os_q         <= {CW{1'b0}};
      drop_q       <= {CW{1'b0}};
      tag_wr_q     <= {TPW{1'b0}};
      tag_rd_q     <= {TPW{1'b0}};
      q_wr_q       <= {QPW{1'b0}};
      q_rd_q       <= {QPW{1'b0}};
      q_cnt_q      <= {QCW{1'b0}};
      head_valid_q <= 1'b0;
      head_pc_q    <= {XLEN{1'b0}};
      head_instr_q <= {XLEN{1'b0}};
      head_err_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      run_q        <= 1'b1;
      os_q         <= os_d;
      drop_q       <= drop_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      q_wr_q       <= q_wr_d;
      q_rd_q       <= q_rd_d;
      q_cnt_q      <= q_cnt_d;
      head_valid_q <= head_valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      head_err_q   <= head_err_d;
    end
  end

  // Tag and instruction storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem_q[i] <= {XLEN{1'b0}};
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_pc_q[i]    <= {XLEN{1'b0}};
        q_instr_q[i] <= {XLEN{1'b0}};
        q_err_q[i]   <= 1'b0;
      end
    end else begin
      if (req_fire_s) begin
        tag_mem_q[tag_wr_q] <= fetch_pc_q;
      end
      if (push_s) begin
        q_pc_q[q_wr_q]    <= tag_s;
        q_instr_q[q_wr_q] <= bus_io.imem_resp_data;
        q_err_q[q_wr_q]   <= bus_io.imem_resp_err;
      end
    end
  end

  assign bus_io.imem_req_valid  = req_valid_s;
  assign bus_io.imem_req_addr   = fetch_pc_q;
  assign bus_io.imem_resp_ready = 1'b1;
  assign bus_io.if_valid        = head_valid_q;
  assign bus_io.if_pc           = head_pc_q;
  assign bus_io.if_instr        = head_instr_q;
  assign bus_io.if_err          = head_err_q;
endmodule
